kbd_ascii_fifo: RTL and testbench
=================================

KBD_ASCII_FIFO -- requirements
Module: kbd_ascii_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; power of two, range 4..64.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_code  input  8  last PS/2 set-2 scan code from the keyboard decode stage; a level held between events.
REQ-005 key_down  input  1  1 = make, 0 = break, for key_code.
REQ-006 rd_en  input  1  pop request from the consumer.
REQ-007 ascii  output  8  FIFO head character; first-word-fall-through; valid only while empty=0.
REQ-008 empty  output  1  FIFO holds no entries.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 count  output  log2(DEPTH)+1  current occupancy.
REQ-011 overflow  output  1  sticky flag: at least one character was dropped.

Function
REQ-012 Event detect: the block registers {key_code, key_down} every cycle; an event occurs in any cycle where the inputs differ from the registered copy.
REQ-013 The block generates no autorepeat; a repeated identical {code, down} pair produces no event.
REQ-014 Shift tracking: make 0x12 or 0x59 sets the respective shift bit; break clears it; shift_active = OR of both bits.
REQ-015 Only make events of mapped codes produce a character; all break events and unmapped codes produce nothing.
REQ-016 Letters (0x1C A, 0x32 B, 0x21 C, 0x23 D, 0x24 E, 0x2B F, 0x34 G, 0x33 H, 0x43 I, 0x3B J, 0x42 K, 0x4B L, 0x3A M, 0x31 N, 0x44 O, 0x4D P, 0x15 Q, 0x2D R, 0x1B S, 0x2C T, 0x3C U, 0x2A V, 0x1D W, 0x22 X, 0x35 Y, 0x1A Z): lowercase ASCII; uppercase when upper = shift_active XOR caps.
REQ-017 Digits (0x45 0, 0x16 1, 0x1E 2, 0x26 3, 0x25 4, 0x2E 5, 0x36 6, 0x3D 7, 0x3E 8, 0x46 9): ASCII digit; with shift_active, the digits 0..9 map to ")!@#$%^&*(".
REQ-018 Fixed keys: 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08; unaffected by shift or caps.
REQ-019 Latency: an event seen in cycle N writes its character at the edge ending cycle N; empty=0 and ascii are valid in cycle N+1.
REQ-020 Pop: rd_en=1 with empty=0 advances the head at the edge; rd_en with empty=1 is ignored and has no side effects.
REQ-021 Push when full with no pop: the character is dropped, overflow is set, and the contents are unchanged.
REQ-022 Push and pop in the same cycle when full: both succeed; count is unchanged; overflow is not set.
REQ-023 Push and pop in the same cycle when empty: the pop is ignored and the push succeeds, so count becomes 1.
REQ-024 Pointers wrap modulo DEPTH; count = write pointer minus read pointer using an extra-bit scheme; full = (count==DEPTH).
REQ-025 overflow remains set until rst.

Reset
REQ-026 rst=1 clears the pointers, count, overflow, shift bits, caps state and the registered input copy {0x00, 0}; empty=1, full=0, ascii=0x00.
REQ-027 rst takes priority over every event and rd_en in the same cycle; a reset issued mid-operation discards all stored characters.
REQ-028 After reset, a first input of {0x00, 0} is not an event.

Configuration
REQ-029 Macro KBD_CAPS_LOCK_EN controls caps-lock support.
REQ-030 With KBD_CAPS_LOCK_EN defined: each make of 0x58 toggles caps, and 0x58 produces no character.
REQ-031 Without KBD_CAPS_LOCK_EN: caps is constant 0, and 0x58 is treated as unmapped.

Verification
REQ-032 Drive make 0x1C, then break 0x1C, then read -> exactly one entry 0x61; empty=1 after the pop.
REQ-033 Make 0x12, make 0x16, break 0x12, make 0x45 -> FIFO holds 0x21, 0x30.
REQ-034 With KBD_CAPS_LOCK_EN: make 0x58, break 0x58, make 0x1C -> 0x41; then make 0x12 and make 0x32 -> 0x62.
REQ-035 Push 17 mapped makes with no reads (DEPTH=16) -> full=1, count=16, overflow=1, and the head is the first character.
REQ-036 With the FIFO full, issue rd_en in the same cycle as a new event -> count stays 16, overflow=0, and the new character is last in order.
REQ-037 Assert rst while count=5 and rd_en=1 -> on the next cycle empty=1, count=0, overflow=0.

Source files
------------

// File: rtl/kbd_ascii_fifo.sv
// kbd_ascii_fifo
//   Turns PS/2 set-2 make/break events into ASCII characters and buffers them
//   in a first-word-fall-through FIFO for a consumer.
//
//   Optional feature: define KBD_CAPS_LOCK_EN to enable caps-lock (0x58 make
//   toggles caps). With the macro undefined, caps is tied to 0 and 0x58 is an
//   unmapped code.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   key_code  in   [7:0] last scan code (level, held between events)
//   key_down  in   1 = make, 0 = break
//   rd_en     in   pop request; ignored while empty
//   ascii     out  [7:0] head character, 0x00 while empty
//   empty     out  FIFO holds no entries
//   full      out  FIFO holds DEPTH entries
//   count     out  [AW:0] occupancy
//   overflow  out  sticky: a character was dropped because the FIFO was full
module kbd_ascii_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_code,
  input  logic        key_down,
  input  logic        rd_en,
  output logic [7:0]  ascii,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic       vld;
    logic [7:0] chr;
  } dec_t;

  // registered copy of the keyboard inputs, used for edge (event) detection
  logic [7:0] prev_code;
  logic       prev_down;
  logic       evt;

  logic       shift_l, shift_r, shift_active;
  logic       caps;
  logic       upper;

  // decode scratch
  logic       is_letter, is_digit;
  logic [4:0] letter_idx;
  logic [3:0] digit_idx;
  logic       is_fixed;
  logic [7:0] fixed_chr;
  logic [7:0] shifted_digit;
  dec_t       dec;

  // FIFO state; pointers carry one extra bit so full and empty differ
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        push, pop, wr_ok;

  assign evt          = (key_code != prev_code) || (key_down != prev_down);
  assign shift_active = shift_l | shift_r;
  assign upper        = shift_active ^ caps;

  // --------------------------------------------------------------------------
  // input registration and modifier tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code <= 8'h00;
      prev_down <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
    end else begin
      prev_code <= key_code;
      prev_down <= key_down;
      if (evt && key_code == 8'h12) shift_l <= key_down;
      if (evt && key_code == 8'h59) shift_r <= key_down;
    end
  end

`ifdef KBD_CAPS_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst)
      caps <= 1'b0;
    else if (evt && key_down && key_code == 8'h58)
      caps <= ~caps;
  end
`else
  assign caps = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // scan code classification
  // --------------------------------------------------------------------------
  always_comb begin
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    case (key_code)
      8'h1C: letter_idx = 5'd0;   // a
      8'h32: letter_idx = 5'd1;   // b
      8'h21: letter_idx = 5'd2;   // c
      8'h23: letter_idx = 5'd3;   // d
      8'h24: letter_idx = 5'd4;   // e
      8'h2B: letter_idx = 5'd5;   // f
      8'h34: letter_idx = 5'd6;   // g
      8'h33: letter_idx = 5'd7;   // h
      8'h43: letter_idx = 5'd8;   // i
      8'h3B: letter_idx = 5'd9;   // j
      8'h42: letter_idx = 5'd10;  // k
      8'h4B: letter_idx = 5'd11;  // l
      8'h3A: letter_idx = 5'd12;  // m
      8'h31: letter_idx = 5'd13;  // n
      8'h44: letter_idx = 5'd14;  // o
      8'h4D: letter_idx = 5'd15;  // p
      8'h15: letter_idx = 5'd16;  // q
      8'h2D: letter_idx = 5'd17;  // r
      8'h1B: letter_idx = 5'd18;  // s
      8'h2C: letter_idx = 5'd19;  // t
      8'h3C: letter_idx = 5'd20;  // u
      8'h2A: letter_idx = 5'd21;  // v
      8'h1D: letter_idx = 5'd22;  // w
      8'h22: letter_idx = 5'd23;  // x
      8'h35: letter_idx = 5'd24;  // y
      8'h1A: letter_idx = 5'd25;  // z
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    is_digit  = 1'b1;
    digit_idx = 4'd0;
    case (key_code)
      8'h45: digit_idx = 4'd0;
      8'h16: digit_idx = 4'd1;
      8'h1E: digit_idx = 4'd2;
      8'h26: digit_idx = 4'd3;
      8'h25: digit_idx = 4'd4;
      8'h2E: digit_idx = 4'd5;
      8'h36: digit_idx = 4'd6;
      8'h3D: digit_idx = 4'd7;
      8'h3E: digit_idx = 4'd8;
      8'h46: digit_idx = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    is_fixed  = 1'b1;
    fixed_chr = 8'h00;
    case (key_code)
      8'h29: fixed_chr = 8'h20;   // space
      8'h5A: fixed_chr = 8'h0D;   // enter
      8'h66: fixed_chr = 8'h08;   // backspace
      default: is_fixed = 1'b0;
    endcase
  end

  // shifted digit row ")!@#$%^&*(" indexed by digit value
  always_comb begin
    shifted_digit = 8'h29;
    case (digit_idx)
      4'd0: shifted_digit = 8'h29;  // )
      4'd1: shifted_digit = 8'h21;  // !
      4'd2: shifted_digit = 8'h40;  // @
      4'd3: shifted_digit = 8'h23;  // #
      4'd4: shifted_digit = 8'h24;  // $
      4'd5: shifted_digit = 8'h25;  // %
      4'd6: shifted_digit = 8'h5E;  // ^
      4'd7: shifted_digit = 8'h26;  // &
      4'd8: shifted_digit = 8'h2A;  // *
      4'd9: shifted_digit = 8'h28;  // (
      default: shifted_digit = 8'h29;
    endcase
  end

  // modifiers used here are the values before this event's own update
  always_comb begin
    dec = '0;
    if (is_letter) begin
      dec.vld = 1'b1;
      dec.chr = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end else if (is_digit) begin
      dec.vld = 1'b1;
      dec.chr = shift_active ? shifted_digit : (8'h30 + {4'b0000, digit_idx});
    end else if (is_fixed) begin
      dec.vld = 1'b1;
      dec.chr = fixed_chr;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign push  = evt && key_down && dec.vld;
  assign pop   = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO succeeds
  assign wr_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr[AW-1:0]] <= dec.chr;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign ascii = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
module tb_kbd_ascii_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       key_down = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] ascii;
  logic       empty, full, overflow;
  logic [4:0] count;

  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_down(key_down),
    .rd_en(rd_en), .ascii(ascii), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  byte unsigned exp_q[$];
  bit  ovf_model = 0, ovf_cur = 0;
  int  pend_push = 0;
  bit  mon_en = 0;
  bit [7:0] pc = 8'h00;
  bit  pd = 0;
  bit  sh_l = 0, sh_r = 0, caps = 0;

  byte unsigned letter_codes[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,
    8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,
    8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  byte unsigned digit_codes[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,
    8'h3D,8'h3E,8'h46};
  byte unsigned shift_digits[10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,
    8'h26,8'h2A,8'h28};

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit map_key(input bit [7:0] c, output byte unsigned ch);
    bit sh = sh_l | sh_r;
    ch = 0;
    for (int i = 0; i < 26; i++)
      if (c == letter_codes[i]) begin
        ch = byte'(((sh ^ caps) ? 65 : 97) + i);
        return 1;
      end
    for (int i = 0; i < 10; i++)
      if (c == digit_codes[i]) begin
        ch = sh ? shift_digits[i] : byte'(48 + i);
        return 1;
      end
    if (c == 8'h29) begin ch = 8'h20; return 1; end
    if (c == 8'h5A) begin ch = 8'h0D; return 1; end
    if (c == 8'h66) begin ch = 8'h08; return 1; end
    return 0;
  endfunction

  // one clock of stimulus; the model decides what the coming edge should do
  task automatic step(input bit [7:0] c, input bit d, input bit r);
    byte unsigned ch;
    bit ev;
    @(posedge clk); #1;
    rst = 0; key_code = c; key_down = d; rd_en = r;
    ev = ({c, d} != {pc, pd});
    pc = c; pd = d;
    if (ev && d && map_key(c, ch)) begin
      if (exp_q.size() == DEPTH && !r) ovf_model = 1;
      else begin exp_q.push_back(ch); pend_push = 1; end
    end
    if (ev) begin
      if (c == 8'h12) sh_l = d;
      if (c == 8'h59) sh_r = d;
`ifdef KBD_CAPS_LOCK_EN
      if (d && c == 8'h58) caps = ~caps;
`endif
    end
  endtask

  task automatic hold(input bit r);
    step(pc, pd, r);
  endtask

  task automatic do_reset(input bit r);
    @(posedge clk); #1;
    rst = 1; rd_en = r;
    pc = 0; pd = 0; sh_l = 0; sh_r = 0; caps = 0;
  endtask

  // monitor: checks pre-edge DUT state against the scoreboard
  always @(negedge clk) begin
    int sz;
    if (mon_en) begin
      sz = exp_q.size() - pend_push;
      chk("empty", int'(empty), int'(sz == 0));
      chk("full", int'(full), int'(sz == DEPTH));
      chk("count", int'(count), sz);
      chk("overflow", int'(overflow), int'(ovf_cur));
      if (!rst && rd_en && sz > 0) begin
        chk("ascii", int'(ascii), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (rst) begin
        exp_q.delete();
        ovf_model = 0;
      end
      ovf_cur = ovf_model;
      pend_push = 0;
    end
  end

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) hold(1);
    hold(0);
  endtask

  initial begin
    byte unsigned pool[] = '{8'h1C,8'h32,8'h1A,8'h45,8'h16,8'h3E,8'h29,8'h5A,
      8'h66,8'h12,8'h59,8'h58,8'h00,8'h76,8'h2B,8'h46};
    repeat (2) @(posedge clk);
    #1; rst = 0; mon_en = 1;
    chk("reset_ascii", int'(ascii), 0);
    hold(0); hold(0);                   // {0,0} after reset: no event

    // make/break A, then read
    step(8'h1C, 1, 0); step(8'h1C, 0, 0); hold(1); hold(0);

    // shifted digit, then unshifted digit
    step(8'h12, 1, 0); step(8'h16, 1, 0); step(8'h12, 0, 0); step(8'h45, 1, 0);
    drain();

`ifdef KBD_CAPS_LOCK_EN
    step(8'h58, 1, 0); step(8'h58, 0, 0); step(8'h1C, 1, 0);
    step(8'h12, 1, 0); step(8'h32, 1, 0); step(8'h12, 0, 0);
    step(8'h58, 1, 0); step(8'h58, 0, 0);
    drain();
`else
    step(8'h58, 1, 0); step(8'h58, 0, 0); step(8'h1C, 1, 0);
    drain();
`endif

    // 17 makes with no reads -> full, overflow, head is first character
    for (int i = 0; i < 17; i++) step(letter_codes[i], 1, 0);
    hold(0);
    drain();

    // full FIFO with pop and push in the same cycle
    do_reset(0);
    for (int i = 0; i < 16; i++) step(letter_codes[i], 1, 0);
    step(letter_codes[20], 1, 1);
    hold(0);
    drain();

    // reset mid-operation with rd_en high
    for (int i = 0; i < 5; i++) step(digit_codes[i], 1, 0);
    do_reset(1);
    hold(0); hold(0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1));
      else if ($urandom_range(0, 3) == 0) hold($urandom_range(0, 2) == 0);
      else begin
        bit [7:0] c;
        if ($urandom_range(0, 9) == 0) c = 8'($urandom);
        else if ($urandom_range(0, 2) == 0) c = letter_codes[$urandom_range(0, 25)];
        else c = pool[$urandom_range(0, 15)];
        step(c, $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 3);
      end
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
